// File: rtl/dcache_ctrl.sv
// Direct-mapped write-back/write-allocate data cache controller with req/ack refill.
// Optional hit/miss counters are built when DCACHE_STATS_EN is defined.
module dcache_ctrl #(
  parameter int unsigned INDEX_W = 4
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         cpu_req_i,
  input  logic         cpu_we_i,
  input  logic [31:0]  cpu_addr_i,
  input  logic [31:0]  cpu_wdata_i,
  output logic [31:0]  cpu_rdata_o,
  output logic         stall_o,
  output logic         mem_req_o,
  output logic         mem_we_o,
  output logic [31:0]  mem_addr_o,
  output logic [255:0] mem_wdata_o,
  input  logic         mem_ack_i,
  input  logic [255:0] mem_rdata_i,
  output logic [31:0]  hit_cnt_o,
  output logic [31:0]  miss_cnt_o
);

  localparam int unsigned LINES = 1 << INDEX_W;
  localparam int unsigned TAG_W = 32 - INDEX_W - 5;

  typedef enum logic [1:0] {S_IDLE, S_WRITEBACK, S_ALLOCATE} state_e;

  state_e              state_q, state_d;
  logic [TAG_W-1:0]    tag_q   [LINES];
  logic [255:0]        data_q  [LINES];
  logic [LINES-1:0]    valid_q, dirty_q;

  logic                mem_req_d, mem_we_d;
  logic [31:0]         mem_addr_d;
  logic [255:0]        mem_wdata_d;

  logic [INDEX_W-1:0]  idx;
  logic [TAG_W-1:0]    req_tag;
  logic [7:0]          wbit;
  logic                hit_c, fill_c, store_hit_c, unused_c;

  assign idx      = cpu_addr_i[INDEX_W+4:5];
  assign req_tag  = cpu_addr_i[31:INDEX_W+5];
  assign wbit     = {cpu_addr_i[4:2], 5'b0};
  assign unused_c = ^cpu_addr_i[1:0];
  assign hit_c    = cpu_req_i & valid_q[idx] & (tag_q[idx] == req_tag);

  // Next-state, memory request and CPU-side responses
  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_o;
    mem_we_d    = mem_we_o;
    mem_addr_d  = mem_addr_o;
    mem_wdata_d = mem_wdata_o;
    stall_o     = 1'b0;
    cpu_rdata_o = 32'h0;
    fill_c      = 1'b0;
    store_hit_c = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (hit_c) begin
          if (cpu_we_i) store_hit_c = 1'b1;
          else          cpu_rdata_o = data_q[idx][wbit +: 32];
        end else if (cpu_req_i) begin
          stall_o   = 1'b1;
          mem_req_d = 1'b1;
          if (valid_q[idx] & dirty_q[idx]) begin
            state_d     = S_WRITEBACK;
            mem_we_d    = 1'b1;
            mem_addr_d  = {tag_q[idx], idx, 5'b0};
            mem_wdata_d = data_q[idx];
          end else begin
            state_d    = S_ALLOCATE;
            mem_we_d   = 1'b0;
            mem_addr_d = {req_tag, idx, 5'b0};
          end
        end
      end
      S_WRITEBACK: begin
        stall_o = 1'b1;
        if (mem_ack_i) begin
          state_d    = S_ALLOCATE;
          mem_we_d   = 1'b0;
          mem_addr_d = {req_tag, idx, 5'b0};
        end
      end
      S_ALLOCATE: begin
        stall_o = 1'b1;
        if (mem_ack_i) begin
          fill_c    = 1'b1;
          state_d   = S_IDLE;
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      valid_q     <= '0;
      dirty_q     <= '0;
      mem_req_o   <= 1'b0;
      mem_we_o    <= 1'b0;
      mem_addr_o  <= 32'h0;
      mem_wdata_o <= '0;
    end else begin
      state_q     <= state_d;
      mem_req_o   <= mem_req_d;
      mem_we_o    <= mem_we_d;
      mem_addr_o  <= mem_addr_d;
      mem_wdata_o <= mem_wdata_d;
      if (fill_c) begin
        valid_q[idx] <= 1'b1;
        dirty_q[idx] <= 1'b0;
      end else if (store_hit_c) begin
        dirty_q[idx] <= 1'b1;
      end
    end
  end

  // Tag and data arrays carry no reset; valid bits qualify them
  always_ff @(posedge clk_i) begin
    if (fill_c) begin
      data_q[idx] <= mem_rdata_i;
      tag_q[idx]  <= req_tag;
    end else if (store_hit_c) begin
      data_q[idx][wbit +: 32] <= cpu_wdata_i;
    end
  end

`ifdef DCACHE_STATS_EN
  logic [31:0] hit_cnt_q, miss_cnt_q;
  logic        refilled_q;

  // The hit that completes a refilled access is part of the miss, not a new hit
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hit_cnt_q  <= 32'h0;
      miss_cnt_q <= 32'h0;
      refilled_q <= 1'b0;
    end else begin
      refilled_q <= fill_c;
      if (state_q == S_IDLE && hit_c && !refilled_q) hit_cnt_q <= hit_cnt_q + 32'd1;
      if (state_q == S_IDLE && state_d != S_IDLE)    miss_cnt_q <= miss_cnt_q + 32'd1;
    end
  end

  assign hit_cnt_o  = hit_cnt_q;
  assign miss_cnt_o = miss_cnt_q;
`else
  assign hit_cnt_o  = 32'h0;
  assign miss_cnt_o = 32'h0;
`endif

endmodule
